// File: rtl/mfp_uart_rx.sv
// 8N1 UART receiver: 2-FF input synchroniser, 16x oversampled mid-bit FSM,
// show-ahead receive FIFO and sticky framing/overrun status flags.
module mfp_uart_rx #(
    parameter int OVS_DIV    = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          rx_in,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    logic          sync_q, rx_s_q;
    logic [DW-1:0] div_q;
    logic          tick;

    state_e        state_q, state_d;
    logic [3:0]    sc_q, sc_d;
    logic [2:0]    bi_q, bi_d;
    logic [7:0]    shift_q, shift_d;
    logic          push, frame_set;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    last_q;
    logic          full, pop, push_ok;
    logic          frame_err_q, overrun_q;

    assign tick = (div_q == DW'(OVS_DIV - 1));

    // Synchroniser and tick divider; the line idles high, so the sync stages reset to 1.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync_q <= 1'b1;
            rx_s_q <= 1'b1;
            div_q  <= '0;
        end else begin
            sync_q <= rx_in;
            rx_s_q <= sync_q;
            div_q  <= tick ? '0 : div_q + DW'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            sc_q    <= '0;
            bi_q    <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            bi_q    <= bi_d;
            shift_q <= shift_d;
        end
    end

    // NOTE: every next-state variable is defaulted first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        bi_d      = bi_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        sc_d    = '0;
                    end
                end
                S_START: begin
                    if (sc_q == 4'd7) begin
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            sc_d    = '0;
                            bi_d    = '0;
                            state_d = S_DATA;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
                S_DATA: begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bi_d    = bi_q + 3'd1;
                        if (bi_q == 3'd7) state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'd15) begin
                        if (rx_s_q) begin
                            push    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            frame_set = 1'b1;
                            state_d   = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = rd_en && (count_q != '0);
    assign push_ok = push && (!full || pop);

    // NOTE: FIFO storage has no reset; validity is tracked by count_q alone.
    always_ff @(posedge HCLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop);
            // Set events take priority over a simultaneous clear.
            if (frame_set)                 frame_err_q <= 1'b1;
            else if (err_clr)              frame_err_q <= 1'b0;
            if (push && full && !pop)      overrun_q   <= 1'b1;
            else if (err_clr)              overrun_q   <= 1'b0;
        end
    end

    // When empty, the most recently popped byte stays visible.
    assign rx_data   = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
    assign rx_valid  = (count_q != '0);
    assign rx_count  = count_q;
    assign rx_busy   = (state_q != S_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mfp_uart_rx.sv
// Directed self-checking bench for mfp_uart_rx with OVS_DIV=2 (32-cycle bits).
module tb_mfp_uart_rx;

    localparam int BIT = 32;

    logic       HCLK = 1'b0;
    logic       HRESET, rx_in, rd_en, err_clr;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, overrun;
    logic [2:0] rx_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int peak      = 0;

    mfp_uart_rx #(.OVS_DIV(2), .FIFO_DEPTH(4)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .rx_in     (rx_in),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_count  (rx_count),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) if (int'(rx_count) > peak) peak = int'(rx_count);

    // Stimulus helpers: entered and left at posedge+1.
    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        idle(BIT);
    endtask

    task automatic send_head(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_head(d);
        drive_bit(1'b1);
    endtask

    task automatic pulse_pop();
        rd_en = 1'b1;
        @(posedge HCLK);
        #1 rd_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge HCLK);
        total_cnt++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_count !== 3'd0 ||
            rx_busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0)
            $display("FAIL reset: data=%h valid=%b count=%0d busy=%b ferr=%b ovr=%b, want 00 0 0 0 0 0",
                     rx_data, rx_valid, rx_count, rx_busy, frame_err, overrun);
        else pass_cnt++;
        @(posedge HCLK); #1;
    endtask

    task automatic test_single_byte();
        idle(10);
        send_byte(8'hA5);
        @(negedge HCLK);
        total_cnt++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5)
            $display("FAIL single data: valid=%b data=%h, want 1 a5", rx_valid, rx_data);
        else pass_cnt++;
        total_cnt++;
        if (rx_count !== 3'd1) $display("FAIL single count: got %0d want 1", rx_count);
        else pass_cnt++;
        total_cnt++;
        if (frame_err !== 1'b0 || rx_busy !== 1'b0)
            $display("FAIL single status: ferr=%b busy=%b, want 0 0", frame_err, rx_busy);
        else pass_cnt++;
        rd_en = 1'b1;
        @(posedge HCLK);
        #1 rd_en = 1'b0;
        @(negedge HCLK);
        total_cnt++;
        if (rx_valid !== 1'b0 || rx_count !== 3'd0)
            $display("FAIL single pop: valid=%b count=%0d, want 0 0", rx_valid, rx_count);
        else pass_cnt++;
        total_cnt++;
        if (rx_data !== 8'hA5) $display("FAIL single hold: data=%h want a5", rx_data);
        else pass_cnt++;
        @(posedge HCLK); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp = '{8'h00, 8'hFF, 8'h3C, 8'h81};
        peak = 0;
        for (int i = 0; i < 4; i++) send_byte(exp[i]);
        idle(4);
        @(negedge HCLK);
        total_cnt++;
        if (rx_count !== 3'd4 || peak != 4)
            $display("FAIL b2b count: count=%0d peak=%0d, want 4 4", rx_count, peak);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (rx_valid !== 1'b1 || rx_data !== exp[i])
                $display("FAIL b2b pop%0d: valid=%b data=%h, want 1 %h", i, rx_valid, rx_data, exp[i]);
            else pass_cnt++;
            pulse_pop();
            @(negedge HCLK);
        end
        total_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL b2b empty: valid=%b want 0", rx_valid);
        else pass_cnt++;
        @(posedge HCLK); #1;
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        @(negedge HCLK);
        total_cnt++;
        if (overrun !== 1'b1 || rx_count !== 3'd4)
            $display("FAIL ovr set: ovr=%b count=%0d, want 1 4", overrun, rx_count);
        else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            total_cnt++;
            if (rx_valid !== 1'b1 || rx_data !== 8'(i))
                $display("FAIL ovr pop%0d: valid=%b data=%h, want 1 %h", i, rx_valid, rx_data, 8'(i));
            else pass_cnt++;
            pulse_pop();
            @(negedge HCLK);
        end
        total_cnt++;
        if (rx_valid !== 1'b0 || overrun !== 1'b1)
            $display("FAIL ovr drained: valid=%b ovr=%b, want 0 1", rx_valid, overrun);
        else pass_cnt++;
        err_clr = 1'b1;
        @(posedge HCLK);
        #1 err_clr = 1'b0;
        @(negedge HCLK);
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL ovr clear: ovr=%b want 0", overrun);
        else pass_cnt++;
        @(posedge HCLK); #1;
    endtask

    task automatic test_glitch();
        idle(10);
        rx_in = 1'b0;
        idle(8);
        rx_in = 1'b1;
        @(negedge HCLK);
        total_cnt++;
        if (rx_busy !== 1'b1) $display("FAIL glitch detect: busy=%b want 1", rx_busy);
        else pass_cnt++;
        idle(40);
        @(negedge HCLK);
        total_cnt++;
        if (rx_busy !== 1'b0 || rx_count !== 3'd0 || frame_err !== 1'b0 || overrun !== 1'b0)
            $display("FAIL glitch: busy=%b count=%0d ferr=%b ovr=%b, want 0 0 0 0",
                     rx_busy, rx_count, frame_err, overrun);
        else pass_cnt++;
        @(posedge HCLK); #1;
    endtask

    task automatic test_frame_break();
        send_head(8'h55);
        drive_bit(1'b0);
        idle(64);
        @(negedge HCLK);
        total_cnt++;
        if (frame_err !== 1'b1 || rx_count !== 3'd0 || rx_busy !== 1'b1)
            $display("FAIL frame set: ferr=%b count=%0d busy=%b, want 1 0 1", frame_err, rx_count, rx_busy);
        else pass_cnt++;
        @(posedge HCLK); #1;
        rx_in = 1'b1;
        idle(BIT);
        send_byte(8'h12);
        @(negedge HCLK);
        total_cnt++;
        if (rx_count !== 3'd1 || rx_data !== 8'h12 || frame_err !== 1'b1)
            $display("FAIL frame recover: count=%0d data=%h ferr=%b, want 1 12 1", rx_count, rx_data, frame_err);
        else pass_cnt++;
        pulse_pop();
        err_clr = 1'b1;
        @(posedge HCLK);
        #1 err_clr = 1'b0;
        @(negedge HCLK);
        total_cnt++;
        if (rx_count !== 3'd0 || frame_err !== 1'b0)
            $display("FAIL frame clear: count=%0d ferr=%b, want 0 0", rx_count, frame_err);
        else pass_cnt++;
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h77;
        idle(10);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_in = d[4];
        idle(BIT / 2);
        @(negedge HCLK);
        total_cnt++;
        if (rx_busy !== 1'b1) $display("FAIL rst busy before: busy=%b want 1", rx_busy);
        else pass_cnt++;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        rx_in = 1'b1;
        @(negedge HCLK);
        total_cnt++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_count !== 3'd0 ||
            rx_busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0)
            $display("FAIL rst mid: data=%h valid=%b count=%0d busy=%b ferr=%b ovr=%b, want 00 0 0 0 0 0",
                     rx_data, rx_valid, rx_count, rx_busy, frame_err, overrun);
        else pass_cnt++;
        @(posedge HCLK); #1;
        idle(40);
        send_byte(8'h9A);
        @(negedge HCLK);
        total_cnt++;
        if (rx_count !== 3'd1 || rx_data !== 8'h9A)
            $display("FAIL rst after: count=%0d data=%h, want 1 9a", rx_count, rx_data);
        else pass_cnt++;
        pulse_pop();
    endtask

    task automatic test_clear_vs_set();
        bit seen;
        seen = 1'b0;
        idle(10);
        send_head(8'h3C);
        rx_in   = 1'b0;
        err_clr = 1'b1;
        // Hold clear across the stop sample; release it once the flag shows up.
        for (int i = 0; i < BIT + 16; i++) begin
            @(negedge HCLK);
            if (frame_err === 1'b1) begin
                seen    = 1'b1;
                err_clr = 1'b0;
                break;
            end
        end
        err_clr = 1'b0;
        total_cnt++;
        if (seen !== 1'b1) $display("FAIL clr vs set: frame_err never rose, got 0 want 1");
        else pass_cnt++;
        @(posedge HCLK); #1;
        idle(8);
        @(negedge HCLK);
        total_cnt++;
        if (frame_err !== 1'b1) $display("FAIL clr vs set hold: ferr=%b want 1", frame_err);
        else pass_cnt++;
        @(posedge HCLK); #1;
        rx_in = 1'b1;
        idle(40);
        @(negedge HCLK);
        total_cnt++;
        if (rx_busy !== 1'b0 || rx_count !== 3'd0)
            $display("FAIL clr vs set end: busy=%b count=%0d, want 0 0", rx_busy, rx_count);
        else pass_cnt++;
    endtask

    initial begin
        HRESET  = 1'b1;
        rx_in   = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_glitch();
        test_frame_break();
        test_reset_mid_frame();
        test_clear_vs_set();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mfp_uart_rx.md
# mfp_uart_rx

Byte-oriented UART receiver that sits directly upstream of `mfp_sys` on the `UART_RX` path of the Nexys4 DDR build. It synchronises the raw serial input and samples it at 16x the baud rate using mid-bit sampling. It assembles 8N1 frames and queues the bytes in a small show-ahead FIFO, which the AHB-side register logic pops with a one-cycle read strobe. Framing errors and FIFO overruns are latched as sticky status bits until software clears them.

## Interface

**Parameters**
- `OVS_DIV`, default 27: number of `HCLK` cycles per 1/16-bit tick. 27 gives about 115200 baud at 50 MHz. Legal values are 1 and above.
- `FIFO_DEPTH`, default 4: number of receive FIFO entries. Must be a power of 2, minimum 2.

**Ports**
- `HCLK`  in  1  System clock, the `clk_wiz_0` output. This is the only clock.
- `HRESET`  in  1  Reset. **Synchronous and active-high.**
- `rx_in`  in  1  Raw serial input, asynchronous to `HCLK`. Idles high.
- `rd_en`  in  1  Pop strobe. When `rx_valid`=1, the head entry is removed. Ignored when the FIFO is empty.
- `err_clr`  in  1  Clears `frame_err` and `overrun`.
- `rx_data`  out  8  Head of the FIFO. Only meaningful when `rx_valid`=1.
- `rx_valid`  out  1  FIFO is non-empty.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1  Current number of FIFO entries.
- `rx_busy`  out  1  A frame is in progress (FSM is not in IDLE).
- `frame_err`  out  1  Sticky flag: a stop bit was sampled as 0.
- `overrun`  out  1  Sticky flag: a byte was dropped because the FIFO was full.

## Operation

**Input synchroniser**
- Two flip-flops on `rx_in` produce `rx_s`. Both reset to 1.

**Tick generator**
- A counter runs from 0 to `OVS_DIV`-1 and pulses `tick` for one cycle at wrap.
- It is free-running and resets to 0.

**Receive FSM** (a 4-bit sub-bit counter `sc` and a 3-bit bit index `bi`)
- **IDLE**: when `rx_s`=0 at a tick, go to START with `sc`=0.
- **START**: count ticks. At `sc`=7 (mid start bit):
  - if `rx_s`=1, treat it as a glitch and return to IDLE;
  - otherwise clear `sc` and `bi` and go to DATA.
- **DATA**: at every `sc`=15 (the mid-bit of each following bit):
  - shift `rx_s` into the shift register MSB, giving LSB-first reception;
  - increment `bi`;
  - after bit 7, go to STOP.
- **STOP**: at `sc`=15, sample the stop bit.
  - If `rx_s`=1, push the byte and go to IDLE.
  - If `rx_s`=0, set `frame_err`, discard the byte and go to BREAK.
- **BREAK**: wait for `rx_s`=1 at a tick, then go to IDLE. This stops a held-low line from being read as repeated frames.

**FIFO**
- Show-ahead circular buffer with read and write pointers that wrap modulo `FIFO_DEPTH`.
- A push when full, with no pop in the same cycle: the byte is dropped and `overrun` is set.
- Simultaneous push and pop when full: the pop frees the slot and the push is accepted. The count stays at `FIFO_DEPTH`.
- Simultaneous push and pop when empty: the push is accepted and the pop is ignored. The count becomes 1.

**Sticky flags**
- `err_clr` clears both flags.
- If a set event and `err_clr` occur in the same cycle, the set wins.

**Reset**
- `HRESET` mid-frame returns the FSM to IDLE, empties the FIFO and discards the partial byte.

## Timing

**Reset values**
- `rx_data`=0x00, `rx_valid`=0, `rx_count`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0.
- The FSM is in IDLE and all counters are 0.

**Latency**
- Synchroniser: 2 `HCLK` cycles.
- A start edge is detected within 1 tick, plus the synchroniser latency.
- `rx_valid` and the updated `rx_count` assert in the cycle after the push. The push happens on the cycle of the stop-bit mid-sample tick.
- `rx_busy` drops in the same cycle as `rx_valid` rises.

**Pop**
- `rd_en` with `rx_valid`=1 takes effect on that clock edge.
- The next entry, or `rx_valid`=0, is visible in the next cycle.
- `rx_data` holds its last value when the FIFO is empty.

**Bit timing**
- Bit period is 16·`OVS_DIV` cycles.
- A full frame is about 10 bit periods; the FSM returns to IDLE at the mid-point of the stop bit.
- Supported baud-rate mismatch is ±3%.

## Test plan

All scenarios use `OVS_DIV`=2, so one bit period is 32 cycles.

- **Single byte**: send 0xA5 as 8N1. Require `rx_valid`=1, `rx_data`=0xA5, `rx_count`=1 and `frame_err`=0. Then pulse `rd_en`; `rx_valid`=0 on the next cycle.
- **Back-to-back bytes**: send 0x00, 0xFF, 0x3C, 0x81 with no idle gap. Popping in order yields exactly that sequence, and `rx_count` peaks at 4.
- **Overrun**: send 5 bytes (0x01–0x05) with no pops. Require `overrun`=1, `rx_count`=4, and pops return 0x01–0x04. Pulse `err_clr`; `overrun`=0.
- **Start-bit glitch**: drive `rx_in` low for 8 cycles, then high. No byte is pushed, `rx_busy` returns to 0 and both flags stay 0.
- **Framing error and break**: send 0x55 with stop bit 0, then hold the line low for 64 cycles, then send 0x12 normally. Require `frame_err`=1, no entry for 0x55, and exactly one entry 0x12.
- **Reset and clear boundaries**:
  - Assert `HRESET` for 1 cycle during data bit 4 of 0x77. All outputs return to reset values, and a following 0x9A is received correctly.
  - Assert `err_clr` in the same cycle as a new frame error. `frame_err` remains 1.
